// File: rtl/keypad_scan_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//
// Shared definitions for the 4x4 hex keypad scanner.
//   - state_e         : scanner FSM states (SCAN, DEBOUNCE, HOLD)
//   - KEY_W, DATA_W   : width of one hex key code and of the digit shift word
//   - N_ROW, N_COL    : keypad matrix dimensions
//   - key_code_of()   : {row_idx, col_idx} -> 4-bit hex key code
//   - lowest_low_row(): index of the lowest-numbered active-low row
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam int KEY_W  = 4;
  localparam int DATA_W = 32;
  localparam int N_ROW  = 4;
  localparam int N_COL  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_e;

  // The hex code is simply the row index in the upper half and the column
  // index in the lower half, so row1/col2 reads as 4'h6.
  function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] row_idx,
                                                   input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

  // Scans from the top row down so the last hit, i.e. the lowest index,
  // wins when several rows are pulled low at once.
  function automatic logic [1:0] lowest_low_row(input logic [N_ROW-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = N_ROW - 1; i >= 0; i--) begin
      if (!rows[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// ---------------------------------------------------------------------------
// keypad_scan_if
//
// Bundles the keypad matrix pins and the key/digit outputs of the scanner.
//   ROW       : keypad rows, active-low, asynchronous to clk
//   clr       : synchronous clear of data_out
//   COL       : column drive, active-low, exactly one bit low
//   key_valid : one-cycle strobe for an accepted key
//   key_code  : hex code of the last accepted key
//   data_out  : shift word of entered digits, newest digit in [3:0]
//
// Modports:
//   master : the scanner (drives COL and the key outputs)
//   slave  : the environment (drives ROW and clr)
// ---------------------------------------------------------------------------
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [N_ROW-1:0]  ROW;
  logic              clr;
  logic [N_COL-1:0]  COL;
  logic              key_valid;
  logic [KEY_W-1:0]  key_code;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  ROW,
    input  clr,
    output COL,
    output key_valid,
    output key_code,
    output data_out
  );

  modport slave (
    output ROW,
    output clr,
    input  COL,
    input  key_valid,
    input  key_code,
    input  data_out
  );

endinterface

// File: rtl/keypad_scan_tick_gen.sv
// ---------------------------------------------------------------------------
// keypad_tick_gen
//
// Free-running divider that marks one clk cycle in every SCAN_DIV as a
// scan/debounce tick. The counter runs 0..SCAN_DIV-1 and tick is high while
// it sits at the terminal count, so the tick lasts exactly one cycle.
//
// Parameters:
//   SCAN_DIV : clk cycles per tick (1..2^20)
// Ports:
//   clk   : system clock
//   rst_n : synchronous, active-low reset (counter back to 0)
//   tick  : one-cycle pulse at the terminal count
// ---------------------------------------------------------------------------
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 40000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // A divide-by-one still needs a one-bit counter that simply stays at 0.
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
//
// 4x4 matrix hex-keypad scanner. One column is driven low at a time, the
// active-low rows are sampled through a 2-FF synchronizer on every scan tick,
// and presses and releases are debounced over DEBOUNCE_SAMPLES ticks. Each
// accepted press produces a one-cycle key_valid strobe with its hex code and
// is shifted into a 32-bit digit word (newest digit in the low nibble).
//
// Optional build macro:
//   KEYPAD_AUTOREPEAT_EN : while a key stays held, re-strobe it every
//                          REPEAT_TICKS ticks (and shift it in again).
//
// Parameters:
//   SCAN_DIV         : clk cycles per scan/debounce tick (1..2^20)
//   DEBOUNCE_SAMPLES : stable ticks needed to accept a press or release (1..15)
//   REPEAT_TICKS     : ticks between auto-repeat strobes
// Ports:
//   clk   : system clock
//   rst_n : synchronous, active-low reset
//   kif   : keypad_scan_if.master (ROW, clr in; COL, key_valid, key_code,
//           data_out out)
// ---------------------------------------------------------------------------
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV         = 40000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned REPEAT_TICKS     = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kif
);

  localparam logic [3:0]       DS       = 4'(DEBOUNCE_SAMPLES);
  localparam logic [N_ROW-1:0] ALL_HIGH = '1;

  logic tick;

  keypad_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Rows are asynchronous to clk; every decision below uses rs_q only.
  logic [N_ROW-1:0] row_meta_q;
  logic [N_ROW-1:0] rs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q <= ALL_HIGH;
      rs_q       <= ALL_HIGH;
    end else begin
      row_meta_q <= kif.ROW;
      rs_q       <= row_meta_q;
    end
  end

  state_e            state_q,     state_d;
  logic [1:0]        col_idx_q,   col_idx_d;
  logic [1:0]        row_idx_q,   row_idx_d;
  logic [N_ROW-1:0]  pat_q,       pat_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [3:0]        rel_q,       rel_d;
  logic              key_valid_q, key_valid_d;
  logic [KEY_W-1:0]  key_code_q,  key_code_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              accept;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned      REP_W    = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);

  logic [REP_W-1:0] rep_q, rep_d;
`else
  // Without auto-repeat REPEAT_TICKS has no effect; it only stays in the
  // parameter list so both builds share one instantiation.
  if (REPEAT_TICKS == 0) begin : g_repeat_unused
  end
`endif

  // Next-state logic. Nothing moves except on tick cycles. The column is
  // frozen while a key is being debounced or held, so the latched row
  // pattern always refers to the same column. Acceptance is funnelled
  // through 'accept' because it can come from SCAN (one-sample debounce)
  // or from DEBOUNCE.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    accept      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
`endif

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (rs_q == ALL_HIGH) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = lowest_low_row(rs_q);
            pat_d     = rs_q;
            cnt_d     = 4'd1;
            if (DS == 4'd1) begin
              accept = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (rs_q == pat_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DS) begin
              accept = 1'b1;
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      HOLD: begin
        // Only a full run of all-high ticks counts as a release; any low
        // row in between, including a second key, restarts the count.
        if (tick) begin
          if (rs_q == ALL_HIGH) begin
            if (rel_q + 4'd1 == DS) begin
              state_d   = SCAN;
              col_idx_d = col_idx_q + 2'd1;
              rel_d     = 4'd0;
            end else begin
              rel_d = rel_q + 4'd1;
            end
          end else begin
            rel_d = 4'd0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rs_q == pat_q) begin
            if (rep_q + REP_W'(1) == REP_LAST) begin
              rep_d       = '0;
              key_valid_d = 1'b1;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    if (accept) begin
      state_d     = HOLD;
      rel_d       = 4'd0;
      key_valid_d = 1'b1;
      key_code_d  = key_code_of(row_idx_d, col_idx_q);
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_d       = '0;
`endif
    end

    // clr beats a simultaneous strobe: the digit is reported on key_code
    // but never lands in the word.
    data_d = data_q;
    if (kif.clr) begin
      data_d = '0;
    end else if (key_valid_q) begin
      data_d = {data_q[DATA_W-KEY_W-1:0], key_code_q};
    end
  end

  // All scanner state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      pat_q       <= ALL_HIGH;
      cnt_q       <= 4'd0;
      rel_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      data_q      <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      data_q      <= data_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  // One-hot-low column decode straight off the column register.
  assign kif.COL       = ~(4'b0001 << col_idx_q);
  assign kif.key_valid = key_valid_q;
  assign kif.key_code  = key_code_q;
  assign kif.data_out  = data_q;

endmodule

// File: tb/tb_keypad_scan.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan
//
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SAMPLES=3 and
// REPEAT_TICKS=5. A small keypad model pulls the pressed key's row low
// whenever its column is driven. A monitor counts key_valid strobes and
// flags any strobe wider than one cycle.
// ---------------------------------------------------------------------------
module tb_keypad_scan;

  logic clk;
  logic rst_n;

  int tests_run;
  int tests_failed;

  // Keypad model state.
  logic       key_down;
  logic [1:0] kr;
  logic [1:0] kc;

  // Strobe monitor.
  int         strobe_total;
  int         wide_pulses;
  logic       prev_valid;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV         (4),
    .DEBOUNCE_SAMPLES (3),
    .REPEAT_TICKS     (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign kif.ROW = (key_down && (kif.COL[kc] == 1'b0)) ? ~(4'b0001 << kr) : 4'hF;

  initial begin
    strobe_total = 0;
    wide_pulses  = 0;
    prev_valid   = 1'b0;
  end

  always @(posedge clk) begin
    #2;
    if (kif.key_valid === 1'b1) begin
      strobe_total = strobe_total + 1;
      if (prev_valid === 1'b1) begin
        wide_pulses = wide_pulses + 1;
      end
    end
    prev_valid = kif.key_valid;
  end

  // Press a key, wait (bounded) for its strobe, keep it held, then release
  // and give the scanner time to debounce the release.
  task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int hold_clks);
    int start;
    start    = strobe_total;
    kr       = r;
    kc       = c;
    key_down = 1'b1;
    for (int i = 0; i < 80 && strobe_total == start; i++) @(negedge clk);
    repeat (hold_clks) @(negedge clk);
    key_down = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    key_down = 1'b0;
    kif.clr  = 1'b0;
    kr       = 2'd0;
    kc       = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (kif.COL !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL reset_col: got %b expected %b", kif.COL, 4'b1110);
    end
    tests_run++;
    if (kif.key_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_key_valid: got %b expected 0", kif.key_valid);
    end
    tests_run++;
    if (kif.key_code !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_key_code: got %h expected 0", kif.key_code);
    end
    tests_run++;
    if (kif.data_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data_out: got %h expected 00000000", kif.data_out);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col [4];
    int start;
    exp_col[0] = 4'b1101;
    exp_col[1] = 4'b1011;
    exp_col[2] = 4'b0111;
    exp_col[3] = 4'b1110;
    start = strobe_total;
    for (int s = 0; s < 4; s++) begin
      repeat (4) @(negedge clk);
      tests_run++;
      if (kif.COL !== exp_col[s]) begin
        tests_failed++;
        $display("[TB] FAIL idle_col_step%0d: got %b expected %b", s, kif.COL, exp_col[s]);
      end
    end
    tests_run++;
    if (strobe_total != start) begin
      tests_failed++;
      $display("[TB] FAIL idle_no_strobe: got %0d strobes expected 0", strobe_total - start);
    end
    tests_run++;
    if (kif.data_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL idle_data_out: got %h expected 00000000", kif.data_out);
    end
  endtask

  task automatic test_single_press();
    int start;
    int lat;
    start    = strobe_total;
    kr       = 2'd1;
    kc       = 2'd2;
    key_down = 1'b1;
    for (int i = 0; i < 40 && kif.COL !== 4'b1011; i++) @(negedge clk);
    lat = 0;
    while (lat < 40 && kif.key_valid !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    // Column reached at edge E; entry tick E+4, debounce completes E+12.
    tests_run++;
    if (lat != 12) begin
      tests_failed++;
      $display("[TB] FAIL press_latency: got %0d clks expected 12", lat);
    end
    tests_run++;
    if (kif.key_code !== 4'h6) begin
      tests_failed++;
      $display("[TB] FAIL press_key_code: got %h expected 6", kif.key_code);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (kif.COL !== 4'b1011) begin
      tests_failed++;
      $display("[TB] FAIL press_col_held: got %b expected 1011", kif.COL);
    end
    key_down = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (kif.COL !== 4'b1011) begin
      tests_failed++;
      $display("[TB] FAIL release_col_held: got %b expected 1011", kif.COL);
    end
    repeat (24) @(negedge clk);
    tests_run++;
    if (strobe_total - start != 1) begin
      tests_failed++;
      $display("[TB] FAIL press_strobe_count: got %0d expected 1", strobe_total - start);
    end
    tests_run++;
    if (kif.data_out !== 32'h00000006) begin
      tests_failed++;
      $display("[TB] FAIL press_data_out: got %h expected 00000006", kif.data_out);
    end
  endtask

  task automatic test_clr();
    int start;
    start   = strobe_total;
    kif.clr = 1'b1;
    @(negedge clk);
    kif.clr = 1'b0;
    tests_run++;
    if (kif.data_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL clr_data_out: got %h expected 00000000", kif.data_out);
    end
    tests_run++;
    if (strobe_total != start) begin
      tests_failed++;
      $display("[TB] FAIL clr_no_strobe: got %0d strobes expected 0", strobe_total - start);
    end
  endtask

  task automatic test_digit_sequence();
    press_key(2'd0, 2'd1, 8);
    press_key(2'd0, 2'd2, 8);
    press_key(2'd0, 2'd3, 8);
    tests_run++;
    if (kif.data_out !== 32'h00000123) begin
      tests_failed++;
      $display("[TB] FAIL seq_123: got %h expected 00000123", kif.data_out);
    end
    tests_run++;
    if (kif.key_code !== 4'h3) begin
      tests_failed++;
      $display("[TB] FAIL seq_key_code_hold: got %h expected 3", kif.key_code);
    end
    for (int i = 0; i < 5; i++) press_key(2'd3, 2'd3, 8);
    tests_run++;
    if (kif.data_out !== 32'h123FFFFF) begin
      tests_failed++;
      $display("[TB] FAIL seq_partial_f: got %h expected 123FFFFF", kif.data_out);
    end
    for (int i = 0; i < 4; i++) press_key(2'd3, 2'd3, 8);
    tests_run++;
    if (kif.data_out !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("[TB] FAIL seq_all_f: got %h expected FFFFFFFF", kif.data_out);
    end
  endtask

  task automatic test_bounce();
    int start;
    logic [3:0] c0;
    start = strobe_total;
    kr    = 2'd0;
    kc    = 2'd0;
    for (int i = 0; i < 12; i++) begin
      key_down = 1'b1;
      repeat (4) @(negedge clk);
      key_down = 1'b0;
      repeat (4) @(negedge clk);
    end
    tests_run++;
    if (strobe_total != start) begin
      tests_failed++;
      $display("[TB] FAIL bounce_no_strobe: got %0d strobes expected 0", strobe_total - start);
    end
    tests_run++;
    if (kif.data_out !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("[TB] FAIL bounce_data_out: got %h expected FFFFFFFF", kif.data_out);
    end
    c0 = kif.COL;
    repeat (4) @(negedge clk);
    tests_run++;
    if (kif.COL === c0) begin
      tests_failed++;
      $display("[TB] FAIL bounce_back_to_scan: got %b expected column to advance from %b", kif.COL, c0);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int start;
    start    = strobe_total;
    kr       = 2'd1;
    kc       = 2'd3;
    for (int i = 0; i < 40 && kif.COL !== 4'b1110; i++) @(negedge clk);
    key_down = 1'b1;
    for (int i = 0; i < 40 && kif.COL !== 4'b0111; i++) @(negedge clk);
    // Entry tick is 4 clks after the column switch; reset lands before the
    // second debounce sample.
    repeat (5) @(negedge clk);
    rst_n    = 1'b0;
    key_down = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (kif.COL !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL midreset_col: got %b expected 1110", kif.COL);
    end
    tests_run++;
    if (kif.data_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_data_out: got %h expected 00000000", kif.data_out);
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (strobe_total != start) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_strobe: got %0d strobes expected 0", strobe_total - start);
    end
  endtask

  task automatic test_clr_collision();
    int start;
    press_key(2'd1, 2'd1, 8);
    tests_run++;
    if (kif.data_out !== 32'h00000005) begin
      tests_failed++;
      $display("[TB] FAIL collide_pre_data: got %h expected 00000005", kif.data_out);
    end
    start    = strobe_total;
    kr       = 2'd2;
    kc       = 2'd2;
    key_down = 1'b1;
    for (int i = 0; i < 80 && kif.key_valid !== 1'b1; i++) @(negedge clk);
    kif.clr = 1'b1;
    @(negedge clk);
    kif.clr = 1'b0;
    tests_run++;
    if (kif.data_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL collide_data_out: got %h expected 00000000", kif.data_out);
    end
    tests_run++;
    if (kif.key_code !== 4'hA) begin
      tests_failed++;
      $display("[TB] FAIL collide_key_code: got %h expected a", kif.key_code);
    end
    repeat (8) @(negedge clk);
    key_down = 1'b0;
    repeat (24) @(negedge clk);
    tests_run++;
    if (strobe_total - start != 1) begin
      tests_failed++;
      $display("[TB] FAIL collide_strobe_count: got %0d expected 1", strobe_total - start);
    end
  endtask

  task automatic test_autorepeat();
    int start;
    int exp_cnt;
    logic [31:0] exp_data;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_cnt  = 5;
    exp_data = 32'h00088888;
`else
    exp_cnt  = 1;
    exp_data = 32'h00000008;
`endif
    start = strobe_total;
    press_key(2'd2, 2'd0, 88);
    tests_run++;
    if (strobe_total - start != exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL hold_strobe_count: got %0d expected %0d", strobe_total - start, exp_cnt);
    end
    tests_run++;
    if (kif.data_out !== exp_data) begin
      tests_failed++;
      $display("[TB] FAIL hold_data_out: got %h expected %h", kif.data_out, exp_data);
    end
    tests_run++;
    if (kif.key_code !== 4'h8) begin
      tests_failed++;
      $display("[TB] FAIL hold_key_code: got %h expected 8", kif.key_code);
    end
  endtask

  task automatic test_pulse_width();
    tests_run++;
    if (wide_pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL strobe_width: got %0d multi-cycle strobes expected 0", wide_pulses);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_idle_scan();
    test_single_press();
    test_clr();
    test_digit_sequence();
    test_bounce();
    test_reset_mid_debounce();
    test_clr_collision();
    test_autorepeat();
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
